pcr_delay_sched_sfp: RTL and testbench

// - Supplies pcr_base_cnt/pcr_ext_cnt to the 1G SFP PCR-amend stage: per-frame transit delay in 27 MHz PCR units.
// - Runs a local 27 MHz timebase from clk. Timestamps each frame at buffer ingress and queues the stamp per good frame.
// - At egress frame start, pops the stamp and computes delay = now - stamp (base/ext format).
// - Holds the result stable for the whole egress frame.

---
 rtl/pcr_sfp_pkg.sv | 20 ++
 rtl/pcr_27m_timebase_sfp.sv | 52 +++++
 rtl/pcr_delay_sched_sfp.sv | 159 +++++++++++++++
 tb/tb_pcr_delay_sched_sfp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pcr_sfp_pkg.sv
// Shared PCR definitions for the 1G SFP delay scheduler.
// Holds the 27 MHz PCR field widths, the extension modulus, the packed
// {base, ext} timestamp type and the ingress FSM state encoding.
package pcr_sfp_pkg;

  localparam int PCR_EXT_MOD = 300;
  localparam int PCR_BASE_W  = 33;
  localparam int PCR_EXT_W   = 9;

  typedef struct packed {
    logic [PCR_BASE_W-1:0] base;
    logic [PCR_EXT_W-1:0]  ext;
  } pcr_ts_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } ing_state_t;

endpackage

// File: rtl/pcr_27m_timebase_sfp.sv
// Local 27 MHz PCR timebase derived from clk by a fractional accumulator.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   now_base  out  33-bit 90 kHz count (wraps mod 2^33)
//   now_ext   out  9-bit 27 MHz remainder, 0..299
module pcr_27m_timebase_sfp
  import pcr_sfp_pkg::*;
#(
  parameter int TICK_NUM = 27,
  parameter int TICK_DEN = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [PCR_BASE_W-1:0] now_base,
  output logic [PCR_EXT_W-1:0]  now_ext
);

  // Wide enough to hold acc + TICK_NUM before the subtract.
  localparam int ACC_W = $clog2(TICK_NUM + TICK_DEN);

  logic [ACC_W-1:0]      r_acc;
  logic [PCR_BASE_W-1:0] r_now_base;
  logic [PCR_EXT_W-1:0]  r_now_ext;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_tick;

  assign w_sum  = r_acc + ACC_W'(TICK_NUM);
  assign w_tick = (w_sum >= ACC_W'(TICK_DEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_now_base <= '0;
      r_now_ext  <= '0;
    end else begin
      r_acc <= w_tick ? (w_sum - ACC_W'(TICK_DEN)) : w_sum;
      if (w_tick) begin
        if (r_now_ext == PCR_EXT_W'(PCR_EXT_MOD - 1)) begin
          r_now_ext  <= '0;
          r_now_base <= r_now_base + 1'b1;
        end else begin
          r_now_ext <= r_now_ext + 1'b1;
        end
      end
    end
  end

  assign now_base = r_now_base;
  assign now_ext  = r_now_ext;

endmodule

// File: rtl/pcr_delay_sched_sfp.sv
// Per-frame transit delay generator for the SFP PCR-amend stage.
// Stamps each ingress frame with the local 27 MHz time, queues stamps of
// accepted frames, and at each egress frame start produces now - stamp in
// PCR base/ext format, held for the whole egress frame.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_en                    ingress byte-valid (frame = contiguous high run)
//   in_good_frame/bad_frame  ingress frame-end strobes (accept / discard)
//   out_en                   egress byte-valid
//   pcr_base_cnt/ext_cnt     delay, 90 kHz part / 27 MHz remainder
//   cnt_valid                outputs hold a delay for the current egress frame
//   fifo_ovf / fifo_udf      1-cycle pulses: commit dropped / pop on empty
module pcr_delay_sched_sfp
  import pcr_sfp_pkg::*;
#(
  parameter int TICK_NUM = 27,
  parameter int TICK_DEN = 125,
  parameter int FIFO_AW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_en,
  input  logic                  in_good_frame,
  input  logic                  in_bad_frame,
  input  logic                  out_en,
  output logic [PCR_BASE_W-1:0] pcr_base_cnt,
  output logic [PCR_EXT_W-1:0]  pcr_ext_cnt,
  output logic                  cnt_valid,
  output logic                  fifo_ovf,
  output logic                  fifo_udf
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [PCR_BASE_W-1:0] w_now_base;
  logic [PCR_EXT_W-1:0]  w_now_ext;

  pcr_27m_timebase_sfp #(
    .TICK_NUM (TICK_NUM),
    .TICK_DEN (TICK_DEN)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .now_base (w_now_base),
    .now_ext  (w_now_ext)
  );

  logic                  r_in_en_d, r_out_en_d;
  ing_state_t            r_state, w_state_next;
  pcr_ts_t               r_stage;
  pcr_ts_t               r_mem [0:DEPTH-1];
  logic [FIFO_AW:0]      r_wr_ptr, r_rd_ptr;
  logic [PCR_BASE_W-1:0] r_base;
  logic [PCR_EXT_W-1:0]  r_ext;
  logic                  r_valid, r_ovf, r_udf;

  logic w_in_rise, w_end_any, w_end_good, w_latch, w_commit;
  logic w_full, w_empty, w_push, w_pop_req, w_pop, w_out_fall;
  logic w_borrow;
  pcr_ts_t               w_head;
  logic [PCR_EXT_W-1:0]  w_dly_ext;
  logic [PCR_BASE_W-1:0] w_dly_base;

  assign w_in_rise  = in_en & ~r_in_en_d;
  assign w_end_any  = in_good_frame | in_bad_frame;
  assign w_end_good = in_good_frame & ~in_bad_frame;   // bad wins a tie

  // Extra pointer bit distinguishes full from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_rise) begin
          w_latch      = 1'b1;
          w_state_next = ST_IN_FRAME;
        end
      end
      ST_IN_FRAME: begin
        if (w_end_any) begin
          w_commit     = w_end_good;
          w_state_next = ST_IDLE;
        end else if (w_in_rise) begin
          w_latch = 1'b1;            // restarted frame: take a fresh stamp
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Full/empty are judged on the pre-update occupancy for both sides.
  assign w_push     = w_commit & ~w_full;
  assign w_pop_req  = out_en & ~r_out_en_d;
  assign w_pop      = w_pop_req & ~w_empty;
  assign w_out_fall = ~out_en & r_out_en_d;

  assign w_head     = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign w_borrow   = (w_now_ext < w_head.ext);
  // 9-bit wraparound is harmless: the true result is always 0..299.
  assign w_dly_ext  = w_borrow ? (w_now_ext + PCR_EXT_W'(PCR_EXT_MOD) - w_head.ext)
                               : (w_now_ext - w_head.ext);
  assign w_dly_base = w_now_base - w_head.base - {{(PCR_BASE_W-1){1'b0}}, w_borrow};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Delayed enables start high so a frame already in progress when
      // reset lifts is not mistaken for a new frame start.
      r_in_en_d  <= 1'b1;
      r_out_en_d <= 1'b1;
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_base     <= '0;
      r_ext      <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_in_en_d  <= in_en;
      r_out_en_d <= out_en;
      r_state    <= w_state_next;
      if (w_latch) begin
        r_stage <= '{base: w_now_base, ext: w_now_ext};
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_base   <= w_dly_base;
        r_ext    <= w_dly_ext;
        r_valid  <= 1'b1;
      end else if ((w_pop_req & w_empty) | w_out_fall) begin
        r_valid <= 1'b0;
      end
      r_ovf <= w_commit & w_full;
      r_udf <= w_pop_req & w_empty;
    end
  end

  assign pcr_base_cnt = r_base;
  assign pcr_ext_cnt  = r_ext;
  assign cnt_valid    = r_valid;
  assign fifo_ovf     = r_ovf;
  assign fifo_udf     = r_udf;

endmodule

// File: tb/tb_pcr_delay_sched_sfp.sv
// Directed bench for pcr_delay_sched_sfp: tick rate, single/filtered frames,
// FIFO overflow/underflow, timebase wrap and reset mid-ingress.
module tb_pcr_delay_sched_sfp;

  logic        clk = 1'b0;
  logic        rst, in_en, in_good_frame, in_bad_frame, out_en;
  logic [32:0] pcr_base_cnt;
  logic [8:0]  pcr_ext_cnt;
  logic        cnt_valid, fifo_ovf, fifo_udf;

  int errors = 0;
  int checks = 0;

  // Reference timebase, advanced once per clock inside cyc().
  int          m_acc;
  logic [32:0] m_base;
  int          m_ext;

  always #5 clk = ~clk;

  pcr_delay_sched_sfp dut (
    .clk           (clk),
    .rst           (rst),
    .in_en         (in_en),
    .in_good_frame (in_good_frame),
    .in_bad_frame  (in_bad_frame),
    .out_en        (out_en),
    .pcr_base_cnt  (pcr_base_cnt),
    .pcr_ext_cnt   (pcr_ext_cnt),
    .cnt_valid     (cnt_valid),
    .fifo_ovf      (fifo_ovf),
    .fifo_udf      (fifo_udf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model follows the DUT edge, returns at the next negedge.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m_acc = 0; m_base = '0; m_ext = 0;
    end else begin
      m_acc += 27;
      if (m_acc >= 125) begin
        m_acc -= 125;
        if (m_ext == 299) begin m_ext = 0; m_base = m_base + 33'd1; end
        else m_ext++;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_now(input logic [32:0] b, input int e);
    int n = 0;
    while (!(m_base == b && m_ext == e) && n < 20000) begin cyc(); n++; end
    chk("wait_now_timeout", 64'(n < 20000), 64'd1);
  endtask

  function automatic logic [41:0] exp_delay(input logic [32:0] nb, input int ne,
                                            input logic [32:0] tb, input int te);
    logic [32:0] b;
    int          x;
    if (ne >= te) begin x = ne - te;       b = nb - tb; end
    else          begin x = ne + 300 - te; b = nb - tb - 33'd1; end
    return {b, 9'(x)};
  endfunction

  task automatic frame_in(input bit good, input bit exp_ovf,
                          output logic [32:0] sb, output int se);
    sb = m_base; se = m_ext;
    in_en = 1'b1; cyc(); cyc(); cyc();
    in_en = 1'b0;
    if (good) in_good_frame = 1'b1; else in_bad_frame = 1'b1;
    cyc();
    in_good_frame = 1'b0; in_bad_frame = 1'b0;
    $display("ingress good=%0d stamp=(%0d,%0d) ovf=%0d", good, sb, se, fifo_ovf);
    chk("ingress_ovf", 64'(fifo_ovf), 64'(exp_ovf));
    cyc();
  endtask

  task automatic pop_chk(input bit exp_valid, input logic [41:0] exp_d);
    out_en = 1'b1; cyc();
    $display("egress valid=%0d base=%0d ext=%0d udf=%0d", cnt_valid, pcr_base_cnt, pcr_ext_cnt, fifo_udf);
    chk("pop_valid", 64'(cnt_valid), 64'(exp_valid));
    chk("pop_udf",   64'(fifo_udf),  64'(!exp_valid));
    chk("pop_base",  64'(pcr_base_cnt), 64'(exp_d[41:9]));
    chk("pop_ext",   64'(pcr_ext_cnt),  64'(exp_d[8:0]));
    cyc();
    chk("hold_valid", 64'(cnt_valid), 64'(exp_valid));
    out_en = 1'b0; cyc();
    chk("fall_valid", 64'(cnt_valid), 64'd0);
    cyc();
  endtask

  initial begin : main
    logic [32:0] sb [0:4];
    int          se [0:4];
    logic [32:0] db;
    int          de;
    logic [41:0] last;

    rst = 1'b1; in_en = 1'b0; in_good_frame = 1'b0; in_bad_frame = 1'b0; out_en = 1'b0;
    m_acc = 0; m_base = '0; m_ext = 0;
    @(negedge clk);
    cyc(); cyc(); cyc();
    chk("rst_valid", 64'(cnt_valid), 64'd0);
    chk("rst_base",  64'(pcr_base_cnt), 64'd0);
    chk("rst_ext",   64'(pcr_ext_cnt), 64'd0);
    chk("rst_ovf",   64'(fifo_ovf), 64'd0);
    chk("rst_udf",   64'(fifo_udf), 64'd0);
    rst = 1'b0;

    // Tick rate: 1250 clocks -> 270 ticks.
    for (int i = 0; i < 1250; i++) cyc();
    $display("tickrate now=(%0d,%0d)", dut.u_timebase.now_base, dut.u_timebase.now_ext);
    chk("tick_ext",  64'(dut.u_timebase.now_ext), 64'd270);
    chk("tick_base", 64'(dut.u_timebase.now_base), 64'd0);

    // Single good frame: stamp (5,290), egress at (6,10) -> (0,20).
    wait_now(33'd5, 290);
    frame_in(1'b1, 1'b0, sb[0], se[0]);
    wait_now(33'd6, 10);
    pop_chk(1'b1, {33'd0, 9'd20});

    // good, bad, good -> pops return stamps 1 and 3.
    frame_in(1'b1, 1'b0, sb[0], se[0]);
    frame_in(1'b0, 1'b0, sb[1], se[1]);
    frame_in(1'b1, 1'b0, sb[2], se[2]);
    for (int i = 0; i < 7; i++) cyc();
    db = m_base; de = m_ext;
    pop_chk(1'b1, exp_delay(db, de, sb[0], se[0]));
    db = m_base; de = m_ext;
    pop_chk(1'b1, exp_delay(db, de, sb[2], se[2]));

    // Five commits into a 4-deep FIFO; fifth overflows.
    for (int i = 0; i < 5; i++) frame_in(1'b1, (i == 4), sb[i], se[i]);
    for (int i = 0; i < 4; i++) begin
      db = m_base; de = m_ext;
      last = exp_delay(db, de, sb[i], se[i]);
      pop_chk(1'b1, last);
    end
    pop_chk(1'b0, last);   // underflow: outputs keep the previous delay

    // Wrap: stamp (2^33-1,299), now (0,1) -> (0,2).
    force dut.u_timebase.r_now_base = 33'h1_FFFF_FFFF;
    force dut.u_timebase.r_now_ext  = 9'd299;
    in_en = 1'b1; cyc();
    release dut.u_timebase.r_now_base;
    release dut.u_timebase.r_now_ext;
    in_en = 1'b0; in_good_frame = 1'b1; cyc();
    in_good_frame = 1'b0; cyc();
    force dut.u_timebase.r_now_base = 33'd0;
    force dut.u_timebase.r_now_ext  = 9'd1;
    out_en = 1'b1; cyc();
    release dut.u_timebase.r_now_base;
    release dut.u_timebase.r_now_ext;
    $display("wrap valid=%0d base=%0d ext=%0d", cnt_valid, pcr_base_cnt, pcr_ext_cnt);
    chk("wrap_valid", 64'(cnt_valid), 64'd1);
    chk("wrap_base",  64'(pcr_base_cnt), 64'd0);
    chk("wrap_ext",   64'(pcr_ext_cnt), 64'd2);
    out_en = 1'b0; cyc();

    // Realign timebase, queue one frame, then reset in the middle of another.
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    frame_in(1'b1, 1'b0, sb[0], se[0]);
    in_en = 1'b1; cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rstmid_valid", 64'(cnt_valid), 64'd0);
    chk("rstmid_base",  64'(pcr_base_cnt), 64'd0);
    in_en = 1'b0; in_good_frame = 1'b1; cyc();
    in_good_frame = 1'b0; cyc();
    chk("rstmid_ovf", 64'(fifo_ovf), 64'd0);
    pop_chk(1'b0, 42'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
